// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed seven-segment scanner with
// hex/BCD glyphs, leading-zero blanking and per-digit blink.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    bcd_mode,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_tick
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] FRAME_MAX = BW'(BLINK_DIV - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [BW-1:0]           frame_q, frame_d;
    logic                    blink_q, blink_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [6:0]              seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;

    logic                    scan_wrap;
    logic                    frame_wrap;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_vec;
    logic [3:0]              nib;
    logic [6:0]              hex_glyph;
    logic [6:0]              glyph;

    // Scan timing: prescaler, digit index, frame counter, blink phase
    always_comb begin
        scan_wrap  = (presc_q == PRESC_MAX);
        frame_wrap = scan_wrap && (idx_q == IDX_MAX);
        presc_d    = scan_wrap ? '0 : presc_q + PW'(1);
        idx_d      = idx_q;
        frame_d    = frame_q;
        blink_d    = blink_q;
        if (scan_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end
        if (frame_wrap) begin
            if (frame_q == FRAME_MAX) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + BW'(1);
            end
        end
        disp_d = load ? value : disp_q;
    end

    // Glyph for the indexed digit, applying blink > zero-blank > dash
    always_comb begin
        zero_run = 1'b1;
        lz_vec   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run  = zero_run && (disp_q[4*k +: 4] == 4'h0);
            lz_vec[k] = zero_run && (k != 0);
        end
        nib = disp_q[4*idx_q +: 4];
        case (nib)
            4'h0:    hex_glyph = 7'h3F;
            4'h1:    hex_glyph = 7'h06;
            4'h2:    hex_glyph = 7'h5B;
            4'h3:    hex_glyph = 7'h4F;
            4'h4:    hex_glyph = 7'h66;
            4'h5:    hex_glyph = 7'h6D;
            4'h6:    hex_glyph = 7'h7D;
            4'h7:    hex_glyph = 7'h07;
            4'h8:    hex_glyph = 7'h7F;
            4'h9:    hex_glyph = 7'h6F;
            4'hA:    hex_glyph = 7'h77;
            4'hB:    hex_glyph = 7'h7C;
            4'hC:    hex_glyph = 7'h39;
            4'hD:    hex_glyph = 7'h5E;
            4'hE:    hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
        glyph = hex_glyph;
        if (bcd_mode && (nib > 4'd9)) glyph = 7'h40;
        if (lz_blank && lz_vec[idx_q]) glyph = 7'h00;
        if (blink_mask[idx_q] && blink_q) glyph = 7'h00;
        seg_n_d        = ~glyph;
        an_n_d         = '1;
        an_n_d[idx_q]  = 1'b0;
    end

    // State and registered display outputs; reset darkens the display
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            blink_q <= 1'b0;
            disp_q  <= '0;
            seg_n_q <= '1;
            an_n_q  <= '1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            disp_q  <= disp_d;
            seg_n_q <= seg_n_d;
            an_n_q  <= an_n_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign an_n       = an_n_q;
    assign frame_tick = frame_wrap && !reset;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: directed and randomized checks of the
// scan driver against a frame-arithmetic reference model.
module tb_seven_seg_scan_driver;
    localparam int N  = 4;
    localparam int S  = 3;
    localparam int BD = 2;
    localparam int F  = N * S;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        bcd_mode = 1'b0;
    logic        lz_blank = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blink_mask = '0;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_tick;
    logic [6:0]  seg1_n;
    logic [0:0]  an1_n;
    logic        frame1_tick;

    int checks = 0;
    int failures = 0;

    // model state: s = edges since the last reset edge
    int          s = 0;
    int          s_prev = 0;
    logic [15:0] md = '0;
    logic [6:0]  exp_seg, exp1_seg;
    logic [3:0]  exp_an;
    logic        exp1_an;
    logic        exp_ft, exp1_ft;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .bcd_mode(bcd_mode), .lz_blank(lz_blank),
        .blink_mask(blink_mask), .seg_n(seg_n), .an_n(an_n),
        .frame_tick(frame_tick)
    );

    seven_seg_scan_driver #(
        .NUM_DIGITS(1), .SCAN_DIV(1), .BLINK_DIV(1)
    ) dut1 (
        .clk(clk), .reset(reset), .value(value[3:0]), .load(load),
        .bcd_mode(bcd_mode), .lz_blank(lz_blank),
        .blink_mask(blink_mask[0:0]), .seg_n(seg1_n), .an_n(an1_n),
        .frame_tick(frame1_tick)
    );

    function automatic logic [6:0] hexglyph(int n);
        case (n)
            0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;
            3: return 7'h4F;   4: return 7'h66;   5: return 7'h6D;
            6: return 7'h7D;   7: return 7'h07;   8: return 7'h7F;
            9: return 7'h6F;  10: return 7'h77;  11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E;  14: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // lit segments shown for state index st of a display
    function automatic logic [6:0] model_lit(int nd, int sd, int bd,
            int st, logic [31:0] disp, logic bcd, logic lz,
            logic [7:0] mask);
        int d, frame, nib;
        d = (st / sd) % nd;
        frame = st / (sd * nd);
        nib = int'((disp >> (4 * d)) & 32'hF);
        if (mask[d] && ((frame / bd) % 2 == 1)) return 7'h00;
        if (lz && d > 0 && (disp >> (4 * d)) == 0) return 7'h00;
        if (bcd && nib > 9) return 7'h40;
        return hexglyph(nib);
    endfunction

    // one clock: predict outputs, advance the model, sample #1 later
    task automatic tick();
        if (reset) begin
            exp_seg = '1; exp_an = '1;
            exp1_seg = '1; exp1_an = 1'b1;
            s = 0; s_prev = -1; md = '0;
        end else begin
            exp_seg = ~model_lit(N, S, BD, s, {16'h0, md},
                bcd_mode, lz_blank, {4'h0, blink_mask});
            exp_an = ~(4'b0001 << ((s / S) % N));
            exp1_seg = ~model_lit(1, 1, 1, s, {28'h0, md[3:0]},
                bcd_mode, lz_blank, {7'h0, blink_mask[0]});
            exp1_an = 1'b0;
            s_prev = s;
            s++;
            if (load) md = value;
        end
        @(posedge clk);
        #1;
        exp_ft = !reset && (s % F == F - 1);
        exp1_ft = !reset;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; value = 16'($urandom);
        repeat (3) begin
            tick();
            checks++;
            if ({seg_n, an_n, frame_tick} !== {7'h7F, 4'hF, 1'b0}) begin
                failures++;
                $display("FAIL reset_idle got seg=%h an=%b ft=%b want seg=7f an=1111 ft=0",
                    seg_n, an_n, frame_tick);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_hex();
        logic [6:0] tab [4];
        logic [3:0] atab [4];
        int d, nft;
        tab[0] = ~7'h71; tab[1] = ~7'h77; tab[2] = ~7'h5B; tab[3] = ~7'h06;
        atab[0] = 4'b1110; atab[1] = 4'b1101;
        atab[2] = 4'b1011; atab[3] = 4'b0111;
        reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if ({seg_n, an_n} !== {7'h7F, 4'hF}) begin
            failures++;
            $display("FAIL post_reset_idle got seg=%h an=%b want seg=7f an=1111",
                seg_n, an_n);
        end
        value = 16'h12AF; load = 1'b1; tick(); load = 1'b0;
        checks++;
        if ({seg_n, an_n} !== {~7'h3F, 4'b1110}) begin
            failures++;
            $display("FAIL first_digit got seg=%h an=%b want seg=%h an=1110",
                seg_n, an_n, ~7'h3F);
        end
        nft = 0;
        for (int i = 0; i < 2 * F; i++) begin
            tick();
            d = (s_prev / S) % N;
            checks++;
            if ({seg_n, an_n} !== {tab[d], atab[d]}) begin
                failures++;
                $display("FAIL hex_digit s=%0d got seg=%h an=%b want seg=%h an=%b",
                    s_prev, seg_n, an_n, tab[d], atab[d]);
            end
            checks++;
            if (frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL hex_tick s=%0d got %b want %b", s, frame_tick, exp_ft);
            end
            if (frame_tick) nft++;
        end
        checks++;
        if (nft !== 2) begin
            failures++;
            $display("FAIL tick_count got %0d want 2", nft);
        end
    endtask

    task automatic test_bcd();
        logic [6:0] tab [4];
        int d;
        tab[0] = ~7'h40; tab[1] = ~7'h40; tab[2] = ~7'h5B; tab[3] = ~7'h06;
        bcd_mode = 1'b1;
        for (int i = 0; i < F; i++) begin
            tick();
            d = (s_prev / S) % N;
            checks++;
            if ({seg_n, an_n} !== {tab[d], ~(4'b0001 << d)}) begin
                failures++;
                $display("FAIL bcd_digit d=%0d got seg=%h an=%b want seg=%h",
                    d, seg_n, an_n, tab[d]);
            end
        end
        bcd_mode = 1'b0;
    endtask

    task automatic test_lz();
        logic [6:0] tab [4];
        int d;
        lz_blank = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            value = (pass == 0) ? 16'h0005 : 16'h0000;
            tab[0] = (pass == 0) ? ~7'h6D : ~7'h3F;
            tab[1] = 7'h7F; tab[2] = 7'h7F; tab[3] = 7'h7F;
            load = 1'b1; tick(); load = 1'b0;
            for (int i = 0; i < F; i++) begin
                tick();
                d = (s_prev / S) % N;
                checks++;
                if ({seg_n, an_n} !== {tab[d], ~(4'b0001 << d)}) begin
                    failures++;
                    $display("FAIL lz_digit v=%h d=%0d got seg=%h an=%b want seg=%h",
                        value, d, seg_n, an_n, tab[d]);
                end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_blink();
        logic [6:0] tab [4];
        logic [6:0] want;
        int d, fr;
        tab[0] = ~7'h71; tab[1] = ~7'h77; tab[2] = ~7'h5B; tab[3] = ~7'h06;
        reset = 1'b1; tick(); reset = 1'b0;
        blink_mask = 4'b0001; value = 16'h12AF; load = 1'b1;
        tick(); load = 1'b0;
        for (int i = 1; i < 6 * F; i++) begin
            tick();
            d = (s_prev / S) % N;
            fr = s_prev / F;
            want = (d == 0 && (fr == 2 || fr == 3)) ? 7'h7F : tab[d];
            checks++;
            if ({seg_n, an_n} !== {want, ~(4'b0001 << d)}) begin
                failures++;
                $display("FAIL blink frame=%0d d=%0d got seg=%h an=%b want seg=%h",
                    fr, d, seg_n, an_n, want);
            end
        end
        blink_mask = '0;
    endtask

    task automatic test_reset_load();
        repeat (7) tick();
        reset = 1'b1; load = 1'b1; value = 16'($urandom) | 16'h1;
        tick();
        checks++;
        if ({seg_n, an_n, frame_tick} !== {7'h7F, 4'hF, 1'b0}) begin
            failures++;
            $display("FAIL reset_load got seg=%h an=%b ft=%b want 7f 1111 0",
                seg_n, an_n, frame_tick);
        end
        reset = 1'b0; load = 1'b0;
        checks++;
        if ({seg_n, an_n} !== {7'h7F, 4'hF}) begin
            failures++;
            $display("FAIL recover_idle got seg=%h an=%b want 7f 1111", seg_n, an_n);
        end
        tick();
        checks++;
        if ({seg_n, an_n} !== {~7'h3F, 4'b1110}) begin
            failures++;
            $display("FAIL recover_zero got seg=%h an=%b want seg=%h an=1110",
                seg_n, an_n, ~7'h3F);
        end
        value = 16'h8888; load = 1'b1; tick(); load = 1'b0;
        repeat (4) tick();
        reset = 1'b1; tick();
        checks++;
        if ({seg_n, an_n, frame_tick} !== {7'h7F, 4'hF, 1'b0}) begin
            failures++;
            $display("FAIL midscan_reset got seg=%h an=%b ft=%b want 7f 1111 0",
                seg_n, an_n, frame_tick);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_digit();
        reset = 1'b1; tick(); reset = 1'b0;
        blink_mask = 4'b0001; value = 16'($urandom); load = 1'b1;
        tick(); load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (seg1_n !== exp1_seg) begin
                failures++;
                $display("FAIL single_seg s=%0d got %h want %h", s_prev, seg1_n, exp1_seg);
            end
            checks++;
            if ({an1_n, frame1_tick} !== {1'b0, 1'b1}) begin
                failures++;
                $display("FAIL single_scan got an=%b ft=%b want an=0 ft=1",
                    an1_n, frame1_tick);
            end
        end
        blink_mask = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            load = ($urandom_range(0, 3) == 0);
            value = ($urandom_range(0, 2) == 0) ?
                16'($urandom_range(0, 255)) : 16'($urandom);
            bcd_mode = 1'($urandom);
            lz_blank = 1'($urandom);
            blink_mask = 4'($urandom);
            tick();
            checks++;
            if ({seg_n, an_n, frame_tick} !== {exp_seg, exp_an, exp_ft}) begin
                failures++;
                $display("FAIL rand4 s=%0d got %h/%b/%b want %h/%b/%b", s,
                    seg_n, an_n, frame_tick, exp_seg, exp_an, exp_ft);
            end
            checks++;
            if ({seg1_n, an1_n, frame1_tick} !== {exp1_seg, exp1_an, exp1_ft}) begin
                failures++;
                $display("FAIL rand1 s=%0d got %h/%b/%b want %h/%b/%b", s,
                    seg1_n, an1_n, frame1_tick, exp1_seg, exp1_an, exp1_ft);
            end
        end
        reset = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hex();
        test_bcd();
        test_lz();
        test_blink();
        test_reset_load();
        test_single_digit();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 The block SHALL have the parameter NUM_DIGITS, default 4: the number of multiplexed digits (1..8).
REQ-002 The block SHALL have the parameter SCAN_DIV, default 50000: the number of clk cycles each digit stays selected (minimum 1).
REQ-003 The block SHALL have the parameter BLINK_DIV, default 64: the number of full scan frames per blink half-period (minimum 1).
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have the port value, input, 4*NUM_DIGITS bits: one nibble per digit; nibble k is value[4k+3:4k] and digit 0 is least significant.
REQ-007 The block SHALL have the port load, input, 1 bit: a strobe that captures value into the internal display register.
REQ-008 The block SHALL have the port bcd_mode, input, 1 bit: 1 shows nibbles 10..15 as a dash; 0 shows them as hex glyphs.
REQ-009 The block SHALL have the port lz_blank, input, 1 bit: 1 enables leading-zero suppression.
REQ-010 The block SHALL have the port blink_mask, input, NUM_DIGITS bits: a 1 makes the corresponding digit blink.
REQ-011 The block SHALL have the port seg_n, output, 7 bits: active-low segments in the order {g,f,e,d,c,b,a}.
REQ-012 The block SHALL have the port an_n, output, NUM_DIGITS bits: active-low digit select, one-hot-low.
REQ-013 The block SHALL have the port frame_tick, output, 1 bit: a one-cycle pulse as digit NUM_DIGITS-1 hands over to digit 0.

Function
REQ-014 Glyphs (active-high lit, {g..a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; dash=40; blank=00; seg_n SHALL equal the bitwise inverse of the selected glyph.
REQ-015 Segment d SHALL be lit exactly for nibbles 0,2,3,5,6,8,9,B,C,D,E in hex mode.
REQ-016 Prescaler: a counter SHALL count 0..SCAN_DIV-1 and wrap to 0; the digit index SHALL advance on each wrap.
REQ-017 The digit index SHALL count 0..NUM_DIGITS-1 and wrap to 0; frame_tick SHALL assert in the cycle the index wraps N-1->0.
REQ-018 Blink: a frame counter SHALL count frame_tick pulses 0..BLINK_DIV-1 and toggle blink_phase on wrap.
REQ-019 When load=1 at edge t, the display register SHALL hold value from t+1; value SHALL be ignored when load=0.
REQ-020 Outputs SHALL be registered: at edge t+1, an_n and seg_n SHALL reflect the digit index and display register as they stood after edge t (one cycle latency).
REQ-021 an_n SHALL drive only the current index low, including while that digit is blanked.
REQ-022 Glyph priority, highest first: blink blank (blink_mask[k]=1 and blink_phase=1) > leading-zero blank > dash (bcd_mode=1 and nibble>9) > hex glyph.
REQ-023 Leading-zero blank: with lz_blank=1, digit k (k>0) SHALL be blank when it and all higher nibbles are 0; digit 0 SHALL never be leading-zero blanked.
REQ-024 With NUM_DIGITS=1, the index SHALL stay 0 and frame_tick SHALL pulse on every prescaler wrap.
REQ-025 With SCAN_DIV=1, the index SHALL advance every cycle.
REQ-026 bcd_mode, lz_blank and blink_mask SHALL be sampled live, with no latching, and take effect under REQ-020 timing.

Reset
REQ-027 While reset=1, seg_n SHALL be all 1, an_n all 1, and frame_tick 0; the prescaler, index, frame counter, blink_phase and display register SHALL be 0.
REQ-028 Reset SHALL dominate load when both are asserted in the same cycle; the display register SHALL be 0 afterwards.
REQ-029 Reset asserted mid-scan SHALL take effect at the next edge regardless of prescaler state.
REQ-030 In the first cycle after reset deasserts, outputs SHALL stay all 1; from the second edge after deassertion, digit 0 SHALL be selected (an_n[0]=0, seg_n=~3F with a zero register).

Verification
REQ-031 The bench SHALL cover: N=4, SCAN_DIV=3, load value=16'h12AF, bcd_mode=0 -> a 12-cycle frame shows digits 0..3 as ~71,~77,~5B,~06 with an_n 1110,1101,1011,0111, and frame_tick pulses once per frame.
REQ-032 The bench SHALL cover: same, bcd_mode=1 -> digits 0 and 1 show ~40 (dash) and digits 2 and 3 are unchanged.
REQ-033 The bench SHALL cover: value=16'h0005, lz_blank=1 -> digits 3..1 show seg_n=7F (blank) while an_n still scans, and digit 0 shows ~6D; with value=0 only digit 0 shows ~3F.
REQ-034 The bench SHALL cover: BLINK_DIV=2, blink_mask=4'b0001 -> digit 0 is blank for frames 2-3, visible for frames 4-5, and the other digits are always visible.
REQ-035 The bench SHALL cover: load and reset asserted together, then mid-scan reset -> all outputs are 1 in the next cycle and the display register reads 0 (digit 0 shows ~3F after recovery).
